// File: rtl/fbr_rr_arbiter.sv
// fbr_rr_arbiter: round-robin sequencer sharing one WIDTH-bit load/set/clear register (FBR) among NREQ requesters.
// Latency: req sampled at edge N gives gnt + strobe in cycle N+1 and done in cycle N+2; at most one op per 3 cycles.
// Backpressure: requesters hold req until their done pulse; losers simply wait. Define FBR_ARB_PRIO0_EN to give requester 0 fixed top priority.
module fbr_rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [2*NREQ-1:0]     op,
    input  logic [WIDTH*NREQ-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic [WIDTH-1:0]      reg_d,
    output logic                  reg_load,
    output logic                  reg_set,
    output logic                  reg_clr,
    output logic [WIDTH-1:0]      q_shadow
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_SET  = 2'b01;
    localparam logic [1:0] OP_CLR  = 2'b10;
    localparam logic [1:0] OP_NOP  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [IW-1:0]     ptr_q;
    logic [IW-1:0]     ptr_nxt;
    logic [IW-1:0]     win_q;
    logic [NREQ-1:0]   win_oh;
    logic [1:0]        op_q;
    logic [WIDTH-1:0]  dat_q;
    logic [WIDTH-1:0]  shadow_q;

    logic              win_vld;
    logic [IW-1:0]     win_idx;
    logic [1:0]        win_op;
    logic [WIDTH-1:0]  win_dat;

    // Pick the next winner: scan from ptr to the top, then wrap and scan from the bottom.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        win_op  = OP_NOP;
        win_dat = '0;
`ifdef FBR_ARB_PRIO0_EN
        // Requester 0 always wins; the rest rotate among 1..NREQ-1 and ptr==0 means "start at 1".
        if (req[0]) begin
            win_vld = 1'b1;
            win_idx = '0;
            win_op  = op[1:0];
            win_dat = wdata[WIDTH-1:0];
        end
        for (int j = 1; j < NREQ; j++) begin
            if (!win_vld && req[j] && (j >= int'(ptr_q))) begin
                win_vld = 1'b1;
                win_idx = IW'(j);
                win_op  = op[2*j +: 2];
                win_dat = wdata[WIDTH*j +: WIDTH];
            end
        end
        for (int j = 1; j < NREQ; j++) begin
            if (!win_vld && req[j]) begin
                win_vld = 1'b1;
                win_idx = IW'(j);
                win_op  = op[2*j +: 2];
                win_dat = wdata[WIDTH*j +: WIDTH];
            end
        end
`else
        for (int j = 0; j < NREQ; j++) begin
            if (!win_vld && req[j] && (j >= int'(ptr_q))) begin
                win_vld = 1'b1;
                win_idx = IW'(j);
                win_op  = op[2*j +: 2];
                win_dat = wdata[WIDTH*j +: WIDTH];
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            if (!win_vld && req[j]) begin
                win_vld = 1'b1;
                win_idx = IW'(j);
                win_op  = op[2*j +: 2];
                win_dat = wdata[WIDTH*j +: WIDTH];
            end
        end
`endif
    end

    // Decode the captured winner index into a one-hot grant vector and compute the pointer advance.
    always_comb begin
        win_oh = '0;
        for (int j = 0; j < NREQ; j++) begin
            win_oh[j] = (int'(win_q) == j);
        end
        ptr_nxt = ptr_q;
`ifdef FBR_ARB_PRIO0_EN
        // Requester 0 grants leave the rotation untouched; the wrap skips over 0.
        if (win_q != '0) begin
            if (int'(win_q) == NREQ - 1) begin
                ptr_nxt = IW'(1);
            end else begin
                ptr_nxt = win_q + IW'(1);
            end
        end
`else
        if (int'(win_q) == NREQ - 1) begin
            ptr_nxt = '0;
        end else begin
            ptr_nxt = win_q + IW'(1);
        end
`endif
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and register-side outputs; strobes only ever come from GRANT.
    always_comb begin
        state_d  = state_q;
        gnt      = '0;
        done     = '0;
        busy     = (state_q != ST_IDLE);
        reg_d    = '0;
        reg_load = 1'b0;
        reg_set  = 1'b0;
        reg_clr  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                gnt = win_oh;
                case (op_q)
                    OP_LOAD: begin
                        reg_load = 1'b1;
                        reg_d    = dat_q;
                    end
                    OP_SET:  reg_set = 1'b1;
                    OP_CLR:  reg_clr = 1'b1;
                    default: ;
                endcase
                state_d = ST_DONE;
            end
            ST_DONE: begin
                gnt     = win_oh;
                done    = win_oh;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture the winner's op/data in IDLE; retire it into the shadow and advance ptr in DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q    <= '0;
            win_q    <= '0;
            op_q     <= OP_NOP;
            dat_q    <= '0;
            shadow_q <= '0;
        end else begin
            if (state_q == ST_IDLE && win_vld) begin
                win_q <= win_idx;
                op_q  <= win_op;
                dat_q <= win_dat;
            end
            if (state_q == ST_DONE) begin
                ptr_q <= ptr_nxt;
                case (op_q)
                    OP_LOAD: shadow_q <= dat_q;
                    OP_SET:  shadow_q <= '1;
                    OP_CLR:  shadow_q <= '0;
                    default: shadow_q <= shadow_q;
                endcase
            end
        end
    end

    assign q_shadow = shadow_q;

endmodule
